aes_op_buf_scheduler: RTL and testbench
=======================================

Name: aes_op_buf_scheduler

Overview:
Round-robin scheduler that shares one aes_encryptor_op_buffer input port among NUM_REQ AES encryption cores.
- Arbitrates among the cores and captures the winner's 128-bit cipher block into a holding register.
- Presents the block to the buffer with valid/ready handshaking and tags it with the source ID.
- Enforces a per-requester burst limit for fairness and keeps a delivered-block counter.
- Sits between the encryptor cores and the output buffer, entirely in the aes_clk domain.

Parameters:
- NUM_REQ, 4, number of requesting AES cores (>=2).
- NO_ROWS, 4, cipher state rows.
- NO_COLS, 4, cipher state columns. Block width BLK_W = NO_ROWS*NO_COLS*8 (128 at defaults).
- MAX_BURST, 2, maximum consecutive grants to one requester while others wait (>=1).
- CNT_W, 16, width of the delivered-block counter.
- ID_W, max(1,$clog2(NUM_REQ)), source ID width (derived, not overridable).

Ports:
- aes_clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = new grants allowed.
- req_vld  input  NUM_REQ  per-core cipher block valid.
- req_cipher_txt  input  NUM_REQ*BLK_W  per-core block. Core k occupies bits [k*BLK_W +: BLK_W]. Byte [r][c] sits at bits [(r*NO_COLS+c)*8 +: 8].
- req_rdy  output  NUM_REQ  one-hot accept; a transfer happens when req_vld[k] & req_rdy[k].
- buf_cipher_txt_vld  output  1  to buffer cipher_txt_vld.
- buf_cipher_txt_rdy  input  1  from buffer cipher_txt_rdy.
- buf_cipher_txt  output  BLK_W  held block, same byte packing as req_cipher_txt.
- buf_src_id  output  ID_W  index of the core that supplied the held block.
- busy  output  1  high while in the XFER state.
- blk_cnt  output  CNT_W  number of blocks delivered to the buffer; wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, checked at the rising edge) values:
  - State IDLE. buf_cipher_txt_vld=0, busy=0, buf_cipher_txt=0, buf_src_id=0, blk_cnt=0.
  - last_win=NUM_REQ-1, burst_cnt=MAX_BURST, so the first search starts at core 0.
  - req_rdy=0 while reset is high.
  - Reset overrides everything, including a block in flight, which is dropped. buf_cipher_txt_vld is low from the first cycle after reset.
- Winner selection is combinational, used only in IDLE:
  - If req_vld[last_win]=1 and burst_cnt<MAX_BURST, the winner is last_win.
  - Otherwise the winner is the first requesting index found scanning last_win+1, last_win+2, ... wrapping modulo NUM_REQ. last_win itself is checked last.
  - No requesters means no winner.
- State IDLE:
  - req_rdy is one-hot on the winner only when enable=1 and a winner exists; otherwise req_rdy=0. req_rdy is combinational from the registered state, last_win, burst_cnt, enable and req_vld.
  - On a handshake: capture the winner's block into buf_cipher_txt and its index into buf_src_id.
  - Update burst_cnt: becomes burst_cnt+1 if winner==last_win, else 1. burst_cnt saturates at MAX_BURST.
  - Set last_win to the winner and go to XFER.
- State XFER:
  - buf_cipher_txt_vld=1, busy=1, req_rdy=0.
  - buf_cipher_txt and buf_src_id stay stable until accepted.
  - On buf_cipher_txt_vld & buf_cipher_txt_rdy: blk_cnt+1 (wrapping), return to IDLE, buf_cipher_txt_vld drops the next cycle.
  - With buf_cipher_txt_rdy=0 the scheduler holds indefinitely.
- Latency and throughput:
  - Handshake in IDLE at edge N gives buf_cipher_txt_vld=1 from cycle N+1.
  - Peak rate is one block per 2 cycles.
- enable=0:
  - Only blocks new grants in IDLE.
  - A block in XFER still completes.
  - last_win and burst_cnt are preserved across disabled periods.
- req_vld may drop without a handshake; the scheduler simply re-evaluates. Data from a non-granted core is never sampled.
- buf_cipher_txt keeps its last value in IDLE; it is not cleared.

Test Plan:
1. Reset check: assert reset for 2 cycles mid-XFER with buf_cipher_txt_rdy=0 -> next cycle buf_cipher_txt_vld=0, busy=0, blk_cnt=0, req_rdy=0. The first grant afterwards with all cores requesting goes to core 0.
2. Single transfer: only core 1 presents bytes [0][0..3]=39,02,dc,19, [1]=25,dc,11,6a, [2]=84,09,85,0b, [3]=1d,fb,97,32 -> req_rdy=4'b0010 in IDLE. Next cycle buf_cipher_txt_vld=1, buf_src_id=1, data bit-exact. Hold buf_cipher_txt_rdy=0 for 5 cycles: output stable, req_rdy=0. Then accept -> blk_cnt=1.
3. Fairness: all 4 cores requesting continuously, buf_cipher_txt_rdy=1, MAX_BURST=2 -> grant order 0,0,1,1,2,2,3,3,0. blk_cnt=8 after 16 cycles.
4. Burst break: cores 0 and 2 requesting, core 0 drops req_vld after its first block -> next grant is core 2, whose burst_cnt=1.
5. enable=0 asserted during XFER -> current block is accepted, then req_rdy stays 0 while enable=0. Re-enable -> next grant continues from last_win+1 per the burst rule.
6. blk_cnt wrap with CNT_W=4: deliver 17 blocks -> blk_cnt=1.

Source files
------------

// File: rtl/aes_op_buf_scheduler.sv
// Round-robin scheduler sharing one op-buffer input port among NUM_REQ AES cores,
// with a per-requester burst limit and a delivered-block counter.
module aes_op_buf_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int NO_ROWS   = 4,
  parameter int NO_COLS   = 4,
  parameter int MAX_BURST = 2,
  parameter int CNT_W     = 16,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BLK_W    = NO_ROWS * NO_COLS * 8
) (
  input  logic                     aes_clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       req_vld,
  input  logic [NUM_REQ*BLK_W-1:0] req_cipher_txt,
  output logic [NUM_REQ-1:0]       req_rdy,
  output logic                     buf_cipher_txt_vld,
  input  logic                     buf_cipher_txt_rdy,
  output logic [BLK_W-1:0]         buf_cipher_txt,
  output logic [ID_W-1:0]          buf_src_id,
  output logic                     busy,
  output logic [CNT_W-1:0]         blk_cnt
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StXfer} state_t;

  state_t              state;
  logic [ID_W-1:0]     last_win;
  logic [BURST_W-1:0]  burst_cnt;
  logic                win_vld;
  logic [ID_W-1:0]     win_idx;
  logic                grant;
  logic [BURST_W-1:0]  burst_nxt;

  // Scan offsets high to low so the nearest requester after last_win is assigned last.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = last_win;
    if (req_vld[last_win] && (burst_cnt < BURST_W'(MAX_BURST))) begin
      win_vld = 1'b1;
    end else begin
      for (int i = NUM_REQ; i >= 1; i--) begin
        idx = (int'(last_win) + i) % NUM_REQ;
        if (req_vld[idx]) begin
          win_vld = 1'b1;
          win_idx = ID_W'(idx);
        end
      end
    end
  end

  always_comb begin
    grant   = (state == StIdle) && enable && win_vld && !reset;
    req_rdy = '0;
    if (grant) begin
      req_rdy[win_idx] = 1'b1;
    end
  end

  always_comb begin
    if (win_idx == last_win) begin
      burst_nxt = (burst_cnt == BURST_W'(MAX_BURST)) ? burst_cnt : burst_cnt + 1'b1;
    end else begin
      burst_nxt = BURST_W'(1);
    end
  end

  always_ff @(posedge aes_clk) begin
    if (reset) begin
      state              <= StIdle;
      buf_cipher_txt_vld <= 1'b0;
      busy               <= 1'b0;
      buf_cipher_txt     <= '0;
      buf_src_id         <= '0;
      blk_cnt            <= '0;
      last_win           <= ID_W'(NUM_REQ - 1);
      burst_cnt          <= BURST_W'(MAX_BURST);
    end else begin
      unique case (state)
        StIdle: begin
          if (grant) begin
            buf_cipher_txt     <= req_cipher_txt[int'(win_idx)*BLK_W +: BLK_W];
            buf_src_id         <= win_idx;
            last_win           <= win_idx;
            burst_cnt          <= burst_nxt;
            state              <= StXfer;
            buf_cipher_txt_vld <= 1'b1;
            busy               <= 1'b1;
          end
        end
        StXfer: begin
          if (buf_cipher_txt_rdy) begin
            blk_cnt            <= blk_cnt + 1'b1;
            state              <= StIdle;
            buf_cipher_txt_vld <= 1'b0;
            busy               <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_op_buf_scheduler.sv
// Randomized bench for aes_op_buf_scheduler: behavioural grant model plus a scoreboard
// queue of expected blocks checked by an independent output monitor.
module tb_aes_op_buf_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int BLK_W     = 128;
  localparam int CNT_W     = 4;
  localparam int MAX_BURST = 2;
  localparam int NCYC      = 2600;

  typedef struct packed {
    logic [1:0]       id;
    logic [BLK_W-1:0] data;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     enable;
  logic [NUM_REQ-1:0]       req_vld;
  logic [NUM_REQ*BLK_W-1:0] req_cipher_txt;
  logic [NUM_REQ-1:0]       req_rdy;
  logic                     buf_vld;
  logic                     buf_rdy;
  logic [BLK_W-1:0]         buf_txt;
  logic [1:0]               buf_src_id;
  logic                     busy;
  logic [CNT_W-1:0]         blk_cnt;

  aes_op_buf_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .NO_ROWS   (4),
    .NO_COLS   (4),
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) dut (
    .aes_clk            (clk),
    .reset              (reset),
    .enable             (enable),
    .req_vld            (req_vld),
    .req_cipher_txt     (req_cipher_txt),
    .req_rdy            (req_rdy),
    .buf_cipher_txt_vld (buf_vld),
    .buf_cipher_txt_rdy (buf_rdy),
    .buf_cipher_txt     (buf_txt),
    .buf_src_id         (buf_src_id),
    .busy               (busy),
    .blk_cnt            (blk_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit   m_init = 0;
  bit   m_just_reset = 0;
  bit   m_xfer = 0;
  int   m_last = NUM_REQ - 1;
  int   m_burst = MAX_BURST;
  int   m_cnt = 0;
  exp_t q[$];

  logic [7:0]       tv [16] = '{8'h39, 8'h02, 8'hdc, 8'h19, 8'h25, 8'hdc, 8'h11, 8'h6a,
                                8'h84, 8'h09, 8'h85, 8'h0b, 8'h1d, 8'hfb, 8'h97, 8'h32};
  logic [BLK_W-1:0] tv_blk;

  task automatic chk(input string name, input logic [BLK_W-1:0] act,
                     input logic [BLK_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Round-robin with burst limit, straight from the selection rules.
  function automatic int pick(input logic [NUM_REQ-1:0] v);
    if (v[m_last] && m_burst < MAX_BURST) return m_last;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (v[(m_last + i) % NUM_REQ]) return (m_last + i) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic int winner();
    if (reset || m_xfer || !enable) return -1;
    return pick(req_vld);
  endfunction

  task automatic drive(input int c);
    logic [NUM_REQ-1:0] v;
    reset   = (c < 2) || (c == 22) || (c == 23) || (c >= 200 && $urandom_range(0, 299) == 0);
    enable  = 1'b1;
    buf_rdy = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_cipher_txt[k*BLK_W +: BLK_W] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    if (c < 18) begin
      req_vld = '1;
    end else if (c < 22) begin
      req_vld = '1;
      buf_rdy = 1'b0;
    end else if (c < 31) begin
      req_vld = '1;
    end else if (c < 46) begin
      req_vld = 4'b0010;
      req_cipher_txt[1*BLK_W +: BLK_W] = tv_blk;
      buf_rdy = (c >= 38);
    end else if (c < 81) begin
      v       = 4'b0100;
      v[0]    = ($urandom_range(0, 2) != 0);
      req_vld = v;
      buf_rdy = ($urandom_range(0, 1) != 0);
    end else if (c < 121) begin
      req_vld = '1;
      enable  = ((c % 20) < 10);
      buf_rdy = ($urandom_range(0, 1) != 0);
    end else begin
      req_vld = NUM_REQ'($urandom());
      enable  = ($urandom_range(0, 7) != 0);
      buf_rdy = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic check_cycle();
    logic [NUM_REQ-1:0] exp_rdy;
    int w;
    w       = winner();
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_rdy", BLK_W'(req_rdy), BLK_W'(exp_rdy));
    chk("buf_vld", BLK_W'(buf_vld), BLK_W'(m_xfer));
    chk("busy", BLK_W'(busy), BLK_W'(m_xfer));
    chk("blk_cnt", BLK_W'(blk_cnt), BLK_W'(m_cnt));
    if (m_just_reset) begin
      chk("rst_txt", buf_txt, '0);
      chk("rst_src_id", BLK_W'(buf_src_id), '0);
    end
  endtask

  task automatic model_step();
    int w;
    exp_t e;
    w = winner();
    if (reset) begin
      m_xfer       = 0;
      m_last       = NUM_REQ - 1;
      m_burst      = MAX_BURST;
      m_cnt        = 0;
      m_init       = 1;
      m_just_reset = 1;
      q.delete();
    end else begin
      m_just_reset = 0;
      if (!m_xfer) begin
        if (w >= 0) begin
          e.id   = 2'(w);
          e.data = req_cipher_txt[w*BLK_W +: BLK_W];
          q.push_back(e);
          m_burst = (w == m_last) ? ((m_burst + 1 > MAX_BURST) ? MAX_BURST : m_burst + 1) : 1;
          m_last  = w;
          m_xfer  = 1;
        end
      end else if (buf_rdy) begin
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        m_xfer = 0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tv_blk[i*8 +: 8] = tv[i];
    reset          = 1'b1;
    enable         = 1'b0;
    req_vld        = '0;
    req_cipher_txt = '0;
    buf_rdy        = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      drive(c);
      @(negedge clk);
      if (m_init) check_cycle();
      #1;
      model_step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Output monitor: compares every presented block against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (m_init && buf_vld === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL monitor: got valid block from id %0d expected no block", buf_src_id);
        end else begin
          chk("buf_txt", buf_txt, q[0].data);
          chk("buf_src_id", BLK_W'(buf_src_id), BLK_W'(q[0].id));
          if (buf_rdy) void'(q.pop_front());
        end
      end
    end
  end

endmodule
